axi4lite_regfile_slave: RTL and testbench
=========================================

AXI4LITE_REGFILE_SLAVE -- requirements
Module: axi4lite_regfile_slave

Interface
REQ-001 SHALL have parameter AXI_ADDR_WIDTH, default 32: byte address width.
REQ-002 SHALL have parameter AXI_DATA_WIDTH, default 32: data width; legal values 32 or 64.
REQ-003 SHALL have parameter NUM_REGS, default 16: register count; power of two, 2..256.
REQ-004 SHALL have parameter RO_MASK, default all-zero (NUM_REGS bits): bit i set makes register i read-only.
REQ-005 SHALL derive AXI_STRB_WIDTH = AXI_DATA_WIDTH/8 and not expose it as a parameter.
REQ-006 SHALL use one clock, A_CLK; reset A_RST is synchronous and active-high.
REQ-007 SHALL have ports:
 A_CLK  in  1  clock, all logic on rising edge
 A_RST  in  1  synchronous active-high reset
 AW_VALID in 1 / AW_READY out 1 / AW_ADDR in AXI_ADDR_WIDTH  write address channel
 W_VALID in 1 / W_READY out 1 / W_DATA in AXI_DATA_WIDTH / W_STRB in AXI_STRB_WIDTH  write data channel
 B_VALID out 1 / B_READY in 1 / B_RESP out 2  write response channel
 AR_VALID in 1 / AR_READY out 1 / AR_ADDR in AXI_ADDR_WIDTH  read address channel
 R_VALID out 1 / R_READY in 1 / R_DATA out AXI_DATA_WIDTH / R_RESP out 2  read data channel

Function
REQ-008 SHALL run read and write paths independently and concurrently; neither path stalls the other.
REQ-009 Decode SHALL be: index = ADDR[log2(AXI_STRB_WIDTH) +: log2(NUM_REGS)]; low byte-offset bits ignored; in range iff ADDR < NUM_REGS*AXI_STRB_WIDTH.
REQ-010 Responses SHALL be: OKAY 2'b00; SLVERR 2'b10 (write to read-only register); DECERR 2'b11 (out of range, read or write).
REQ-011 Write FSM SHALL have states WR_IDLE and WR_RESP.
REQ-012 In WR_IDLE, AW_READY SHALL be high while no address is latched; W_READY high while no data/strobe is latched; each channel may handshake in any order, including the same cycle.
REQ-013 On the edge completing the second of the AW/W handshakes: register updated (OKAY case only), B_RESP registered, B_VALID high from the next cycle, FSM -> WR_RESP.
REQ-014 Register update SHALL write byte lane k only where W_STRB[k]=1; W_STRB all-zero yields OKAY with no change.
REQ-015 SLVERR and DECERR writes SHALL leave every register unchanged.
REQ-016 In WR_RESP, AW_READY=W_READY=0; B_VALID and B_RESP held stable until B_READY; on B handshake, latches cleared, FSM -> WR_IDLE, AW_READY/W_READY high the next cycle.
REQ-017 Read FSM SHALL have states RD_IDLE (AR_READY=1, R_VALID=0) and RD_DATA (AR_READY=0, R_VALID=1).
REQ-018 On AR handshake: R_DATA and R_RESP registered, FSM -> RD_DATA; R_VALID high the next cycle (latency 1).
REQ-019 R_DATA SHALL be the register value for OKAY and all-zero for DECERR; write-only registers do not exist.
REQ-020 R_DATA/R_RESP SHALL hold stable until the R handshake, then FSM -> RD_IDLE; minimum read period is 2 cycles.
REQ-021 A read captured on the same edge as a write to the same register SHALL return the pre-write value.
REQ-022 All outputs SHALL be registered or decoded from FSM state only; no combinational path from any input to any output.

Reset
REQ-023 While A_RST=1 at an edge: all registers = 0, both FSMs idle, latches cleared, B_VALID=R_VALID=0, B_RESP=R_RESP=2'b00, R_DATA=0, AW_READY=W_READY=AR_READY=0.
REQ-024 From the first edge with A_RST=0: AW_READY, W_READY and AR_READY high.
REQ-025 Reset mid-transaction SHALL discard any latched address/data and pending response without modifying registers.

Verification
REQ-026 Write 0x08 data 0xDEADBEEF strb 4'hF (AW, W same cycle), B_READY=1 -> B_VALID one cycle later, B_RESP=00; read 0x08 -> R_DATA=0xDEADBEEF, R_RESP=00.
REQ-027 W three cycles before AW (addr 0x04, data 0x11223344, strb 4'b0101) onto reg value 0xFFFFFFFF -> single B with OKAY; readback 0xFF22FF44.
REQ-028 NUM_REGS=16, write 0x40 data 0x1 -> B_RESP=11, no register changed; read 0x40 -> R_RESP=11, R_DATA=0.
REQ-029 RO_MASK bit 2 set, write 0x08 data 0x5 -> B_RESP=10; readback 0x08 = 0 (reset value).
REQ-030 B_READY=0 for 5 cycles, then 1 -> B_VALID/B_RESP stable throughout, AW_READY/W_READY low; meanwhile read 0x0 completes with R_VALID one cycle after AR.
REQ-031 Assert A_RST one cycle after the AW handshake (W pending) -> next cycle B_VALID=0, all registers 0; a subsequent W alone produces no B.

Source files
------------

// File: rtl/axi4lite_regfile_slave.sv
// AXI4-Lite register file slave with independent read and write paths; B one cycle after the last of AW/W, R one cycle after AR.
// Backpressure: AW/W/AR READY stay low while their response is pending; B and R hold stable until accepted.
module axi4lite_regfile_slave #(
    parameter int                  AXI_ADDR_WIDTH = 32,
    parameter int                  AXI_DATA_WIDTH = 32,
    parameter int                  NUM_REGS       = 16,
    parameter logic [NUM_REGS-1:0] RO_MASK        = '0
) (
    input  logic                        A_CLK,
    input  logic                        A_RST,
    input  logic                        AW_VALID,
    output logic                        AW_READY,
    input  logic [AXI_ADDR_WIDTH-1:0]   AW_ADDR,
    input  logic                        W_VALID,
    output logic                        W_READY,
    input  logic [AXI_DATA_WIDTH-1:0]   W_DATA,
    input  logic [AXI_DATA_WIDTH/8-1:0] W_STRB,
    output logic                        B_VALID,
    input  logic                        B_READY,
    output logic [1:0]                  B_RESP,
    input  logic                        AR_VALID,
    output logic                        AR_READY,
    input  logic [AXI_ADDR_WIDTH-1:0]   AR_ADDR,
    output logic                        R_VALID,
    input  logic                        R_READY,
    output logic [AXI_DATA_WIDTH-1:0]   R_DATA,
    output logic [1:0]                  R_RESP
);
    localparam int STRB_W   = AXI_DATA_WIDTH / 8;
    localparam int ADDR_LSB = $clog2(STRB_W);
    localparam int IDX_W    = $clog2(NUM_REGS);
    localparam int TOP_LSB  = ADDR_LSB + IDX_W;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;
    typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;

    wr_state_t                 wr_state_q, wr_state_d;
    rd_state_t                 rd_state_q, rd_state_d;
    logic                      aw_vld_q, aw_vld_d, w_vld_q, w_vld_d;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
    logic [AXI_DATA_WIDTH-1:0] w_dat_q, w_dat_d;
    logic [STRB_W-1:0]         w_strb_q, w_strb_d;
    logic                      aw_rdy_q, aw_rdy_d, w_rdy_q, w_rdy_d, ar_rdy_q, ar_rdy_d;
    logic                      b_vld_q, b_vld_d, r_vld_q, r_vld_d;
    logic [1:0]                b_resp_q, b_resp_d, r_resp_q, r_resp_d;
    logic [AXI_DATA_WIDTH-1:0] r_dat_q, r_dat_d;
    logic [AXI_DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [AXI_DATA_WIDTH-1:0] regs_d [NUM_REGS];

    logic                      aw_hs, w_hs, b_hs, ar_hs, r_hs, wr_go;
    logic [AXI_ADDR_WIDTH-1:0] wr_addr;
    logic [AXI_DATA_WIDTH-1:0] wr_dat;
    logic [STRB_W-1:0]         wr_strb;
    logic [IDX_W-1:0]          wr_idx, rd_idx;
    logic                      wr_in_range, rd_in_range;
    logic [1:0]                wr_resp;

    assign aw_hs = AW_VALID && aw_rdy_q;
    assign w_hs  = W_VALID && w_rdy_q;
    assign b_hs  = b_vld_q && B_READY;
    assign ar_hs = AR_VALID && ar_rdy_q;
    assign r_hs  = r_vld_q && R_READY;

    // A channel handshaking this cycle is used directly so AW and W may complete on the same edge.
    assign wr_addr     = aw_vld_q ? aw_addr_q : AW_ADDR;
    assign wr_dat      = w_vld_q ? w_dat_q : W_DATA;
    assign wr_strb     = w_vld_q ? w_strb_q : W_STRB;
    assign wr_go       = (wr_state_q == WR_IDLE) && (aw_vld_q || aw_hs) && (w_vld_q || w_hs);
    assign wr_idx      = wr_addr[ADDR_LSB +: IDX_W];
    assign wr_in_range = (wr_addr >> TOP_LSB) == '0;
    assign wr_resp     = !wr_in_range     ? RESP_DECERR :
                         RO_MASK[wr_idx]  ? RESP_SLVERR : RESP_OKAY;
    assign rd_idx      = AR_ADDR[ADDR_LSB +: IDX_W];
    assign rd_in_range = (AR_ADDR >> TOP_LSB) == '0;

    always_ff @(posedge A_CLK) begin
        if (A_RST) begin
            wr_state_q <= WR_IDLE;
            rd_state_q <= RD_IDLE;
            aw_vld_q   <= 1'b0;
            w_vld_q    <= 1'b0;
            aw_addr_q  <= '0;
            w_dat_q    <= '0;
            w_strb_q   <= '0;
            aw_rdy_q   <= 1'b0;
            w_rdy_q    <= 1'b0;
            ar_rdy_q   <= 1'b0;
            b_vld_q    <= 1'b0;
            r_vld_q    <= 1'b0;
            b_resp_q   <= RESP_OKAY;
            r_resp_q   <= RESP_OKAY;
            r_dat_q    <= '0;
            regs_q     <= '{default: '0};
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            aw_vld_q   <= aw_vld_d;
            w_vld_q    <= w_vld_d;
            aw_addr_q  <= aw_addr_d;
            w_dat_q    <= w_dat_d;
            w_strb_q   <= w_strb_d;
            aw_rdy_q   <= aw_rdy_d;
            w_rdy_q    <= w_rdy_d;
            ar_rdy_q   <= ar_rdy_d;
            b_vld_q    <= b_vld_d;
            r_vld_q    <= r_vld_d;
            b_resp_q   <= b_resp_d;
            r_resp_q   <= r_resp_d;
            r_dat_q    <= r_dat_d;
            regs_q     <= regs_d;
        end
    end

    always_comb begin
        wr_state_d = wr_state_q;
        rd_state_d = rd_state_q;
        case (wr_state_q)
            WR_IDLE: if (wr_go) wr_state_d = WR_RESP;
            WR_RESP: if (b_hs)  wr_state_d = WR_IDLE;
        endcase
        case (rd_state_q)
            RD_IDLE: if (ar_hs) rd_state_d = RD_DATA;
            RD_DATA: if (r_hs)  rd_state_d = RD_IDLE;
        endcase
    end

    always_comb begin
        aw_vld_d  = aw_vld_q;
        w_vld_d   = w_vld_q;
        aw_addr_d = aw_addr_q;
        w_dat_d   = w_dat_q;
        w_strb_d  = w_strb_q;
        b_resp_d  = b_resp_q;
        regs_d    = regs_q;
        if (wr_state_q == WR_IDLE) begin
            if (aw_hs) begin
                aw_vld_d  = 1'b1;
                aw_addr_d = AW_ADDR;
            end
            if (w_hs) begin
                w_vld_d  = 1'b1;
                w_dat_d  = W_DATA;
                w_strb_d = W_STRB;
            end
            if (wr_go) begin
                b_resp_d = wr_resp;
                if (wr_resp == RESP_OKAY) begin
                    for (int k = 0; k < STRB_W; k++) begin
                        if (wr_strb[k]) regs_d[wr_idx][8*k +: 8] = wr_dat[8*k +: 8];
                    end
                end
            end
        end else if (b_hs) begin
            aw_vld_d = 1'b0;
            w_vld_d  = 1'b0;
        end
        aw_rdy_d = (wr_state_d == WR_IDLE) && !aw_vld_d;
        w_rdy_d  = (wr_state_d == WR_IDLE) && !w_vld_d;
        b_vld_d  = (wr_state_d == WR_RESP);
    end

    // Read data comes from the pre-edge register image, so a same-edge write is not visible.
    always_comb begin
        r_dat_d  = r_dat_q;
        r_resp_d = r_resp_q;
        if (ar_hs) begin
            r_resp_d = rd_in_range ? RESP_OKAY : RESP_DECERR;
            r_dat_d  = rd_in_range ? regs_q[rd_idx] : '0;
        end
        ar_rdy_d = (rd_state_d == RD_IDLE);
        r_vld_d  = (rd_state_d == RD_DATA);
    end

    assign AW_READY = aw_rdy_q;
    assign W_READY  = w_rdy_q;
    assign B_VALID  = b_vld_q;
    assign B_RESP   = b_resp_q;
    assign AR_READY = ar_rdy_q;
    assign R_VALID  = r_vld_q;
    assign R_DATA   = r_dat_q;
    assign R_RESP   = r_resp_q;
endmodule

// File: tb/tb_axi4lite_regfile_slave.sv
// Bench for axi4lite_regfile_slave: two instances (no read-only regs, reg 2 read-only) share stimulus.
module tb_axi4lite_regfile_slave;
    logic        A_CLK = 1'b0;
    logic        A_RST, AW_VALID, W_VALID, B_READY, AR_VALID, R_READY;
    logic [31:0] AW_ADDR, W_DATA, AR_ADDR;
    logic [3:0]  W_STRB;

    logic [1:0]       aw_rdy, w_rdy, b_vld, ar_rdy, r_vld;
    logic [1:0][1:0]  b_resp, r_resp;
    logic [1:0][31:0] r_dat;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 A_CLK = ~A_CLK;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        axi4lite_regfile_slave #(.RO_MASK((g == 1) ? 16'h0004 : 16'h0000)) u_dut (
            .A_CLK(A_CLK), .A_RST(A_RST),
            .AW_VALID(AW_VALID), .AW_READY(aw_rdy[g]), .AW_ADDR(AW_ADDR),
            .W_VALID(W_VALID), .W_READY(w_rdy[g]), .W_DATA(W_DATA), .W_STRB(W_STRB),
            .B_VALID(b_vld[g]), .B_READY(B_READY), .B_RESP(b_resp[g]),
            .AR_VALID(AR_VALID), .AR_READY(ar_rdy[g]), .AR_ADDR(AR_ADDR),
            .R_VALID(r_vld[g]), .R_READY(R_READY), .R_DATA(r_dat[g]), .R_RESP(r_resp[g])
        );
    end

    task automatic chk(input string nm, input int inst, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] got %h expected %h at %0t", nm, inst, act, exp, $time);
        end
    endtask

    task automatic tmo(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s timed out at %0t", nm, $time);
    endtask

    // Transaction-level reference: register image per instance plus outstanding-response flags.
    logic [31:0] mem [2][16];
    logic [15:0] ro_mask [2] = '{16'h0000, 16'h0004};
    logic        was_rst = 1'b1, aw_have = 1'b0, w_have = 1'b0, exp_bvld = 1'b0, exp_rvld = 1'b0;
    logic [31:0] m_aw_addr, m_w_dat;
    logic [3:0]  m_w_strb;
    logic [1:0]  exp_bresp [2], exp_rresp [2];
    logic [31:0] exp_rdat [2];

    initial begin
        forever begin
            @(negedge A_CLK);
            for (int i = 0; i < 2; i++) begin
                if (was_rst) begin
                    chk("rst_aw_ready", i, aw_rdy[i], 0);
                    chk("rst_w_ready", i, w_rdy[i], 0);
                    chk("rst_ar_ready", i, ar_rdy[i], 0);
                    chk("rst_b_valid", i, b_vld[i], 0);
                    chk("rst_r_valid", i, r_vld[i], 0);
                    chk("rst_b_resp", i, b_resp[i], 0);
                    chk("rst_r_resp", i, r_resp[i], 0);
                    chk("rst_r_data", i, r_dat[i], 0);
                end else begin
                    chk("aw_ready", i, aw_rdy[i], !aw_have && !exp_bvld);
                    chk("w_ready", i, w_rdy[i], !w_have && !exp_bvld);
                    chk("ar_ready", i, ar_rdy[i], !exp_rvld);
                    chk("b_valid", i, b_vld[i], exp_bvld);
                    if (exp_bvld) chk("b_resp", i, b_resp[i], exp_bresp[i]);
                    chk("r_valid", i, r_vld[i], exp_rvld);
                    if (exp_rvld) begin
                        chk("r_data", i, r_dat[i], exp_rdat[i]);
                        chk("r_resp", i, r_resp[i], exp_rresp[i]);
                    end
                end
            end
            // Predict the effect of the coming rising edge from the inputs now stable.
            if (A_RST) begin
                for (int i = 0; i < 2; i++)
                    for (int r = 0; r < 16; r++) mem[i][r] = 32'h0;
                was_rst = 1'b1; aw_have = 1'b0; w_have = 1'b0; exp_bvld = 1'b0; exp_rvld = 1'b0;
            end else begin
                if (!was_rst && !exp_rvld && AR_VALID) begin
                    for (int i = 0; i < 2; i++) begin
                        exp_rresp[i] = (AR_ADDR < 32'd64) ? 2'b00 : 2'b11;
                        exp_rdat[i]  = (AR_ADDR < 32'd64) ? mem[i][AR_ADDR[5:2]] : 32'h0;
                    end
                    exp_rvld = 1'b1;
                end else if (exp_rvld && R_READY) begin
                    exp_rvld = 1'b0;
                end
                if (exp_bvld) begin
                    if (B_READY) begin
                        exp_bvld = 1'b0; aw_have = 1'b0; w_have = 1'b0;
                    end
                end else if (!was_rst) begin
                    if (AW_VALID && !aw_have) begin aw_have = 1'b1; m_aw_addr = AW_ADDR; end
                    if (W_VALID && !w_have) begin w_have = 1'b1; m_w_dat = W_DATA; m_w_strb = W_STRB; end
                    if (aw_have && w_have) begin
                        for (int i = 0; i < 2; i++) begin
                            if (m_aw_addr >= 32'd64)                    exp_bresp[i] = 2'b11;
                            else if (ro_mask[i][m_aw_addr[5:2]])        exp_bresp[i] = 2'b10;
                            else begin
                                exp_bresp[i] = 2'b00;
                                for (int k = 0; k < 4; k++)
                                    if (m_w_strb[k]) mem[i][m_aw_addr[5:2]][8*k +: 8] = m_w_dat[8*k +: 8];
                            end
                        end
                        exp_bvld = 1'b1;
                    end
                end
                was_rst = 1'b0;
            end
        end
    end

    task automatic send_aw(input logic [31:0] addr, input int lead);
        bit ok = 0;
        repeat (lead) begin @(posedge A_CLK); #1; end
        AW_ADDR = addr; AW_VALID = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge A_CLK);
            if (aw_rdy[0]) begin ok = 1; break; end
        end
        if (!ok) tmo("aw_handshake");
        @(posedge A_CLK); #1 AW_VALID = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] data, input logic [3:0] strb, input int lead);
        bit ok = 0;
        repeat (lead) begin @(posedge A_CLK); #1; end
        W_DATA = data; W_STRB = strb; W_VALID = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge A_CLK);
            if (w_rdy[0]) begin ok = 1; break; end
        end
        if (!ok) tmo("w_handshake");
        @(posedge A_CLK); #1 W_VALID = 1'b0;
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                      input int w_lead, input int aw_lead, input logic [1:0] r0, input logic [1:0] r1);
        bit ok = 0;
        fork
            send_aw(addr, aw_lead);
            send_w(data, strb, w_lead);
        join
        @(negedge A_CLK);
        if (!b_vld[0]) tmo("b_valid_after_write");
        chk("b_resp_lit", 0, b_resp[0], r0);
        chk("b_resp_lit", 1, b_resp[1], r1);
        for (int c = 0; c < 30; c++) begin
            if (B_READY) begin ok = 1; break; end
            @(negedge A_CLK);
        end
        if (!ok) tmo("b_handshake");
        @(posedge A_CLK); #1;
    endtask

    task automatic rd(input logic [31:0] addr, input logic [31:0] d0, input logic [1:0] r0,
                      input logic [31:0] d1, input logic [1:0] r1, input int stall);
        bit ok = 0;
        R_READY = (stall == 0);
        AR_ADDR = addr; AR_VALID = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge A_CLK);
            if (ar_rdy[0]) begin ok = 1; break; end
        end
        if (!ok) tmo("ar_handshake");
        @(posedge A_CLK); #1 AR_VALID = 1'b0;
        @(negedge A_CLK);
        chk("r_latency", 0, r_vld[0], 1);
        chk("r_data_lit", 0, r_dat[0], d0);
        chk("r_resp_lit", 0, r_resp[0], r0);
        chk("r_data_lit", 1, r_dat[1], d1);
        chk("r_resp_lit", 1, r_resp[1], r1);
        repeat (stall) begin @(posedge A_CLK); #1; end
        R_READY = 1'b1;
        @(posedge A_CLK); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        A_RST = 1'b1; AW_VALID = 1'b0; W_VALID = 1'b0; AR_VALID = 1'b0;
        B_READY = 1'b1; R_READY = 1'b1;
        AW_ADDR = '0; W_DATA = '0; W_STRB = '0; AR_ADDR = '0;
        repeat (3) @(posedge A_CLK);
        @(negedge A_CLK);
        chk("reset_aw_ready_lit", 0, aw_rdy[0], 0);
        chk("reset_ar_ready_lit", 0, ar_rdy[0], 0);
        @(posedge A_CLK); #1 A_RST = 1'b0;
        @(negedge A_CLK);
        @(negedge A_CLK);
        chk("post_reset_aw_ready_lit", 0, aw_rdy[0], 1);
        chk("post_reset_w_ready_lit", 0, w_rdy[0], 1);
        chk("post_reset_ar_ready_lit", 0, ar_rdy[0], 1);
        @(posedge A_CLK); #1;

        // Simultaneous AW/W, then readback; instance 1 rejects the read-only register.
        wr(32'h08, 32'hDEADBEEF, 4'hF, 0, 0, 2'b00, 2'b10);
        rd(32'h08, 32'hDEADBEEF, 2'b00, 32'h0, 2'b00, 0);
        wr(32'h08, 32'h5, 4'hF, 0, 0, 2'b00, 2'b10);
        rd(32'h0A, 32'h5, 2'b00, 32'h0, 2'b00, 0);

        // W leads AW by three cycles with a sparse strobe; readback held under R stall.
        wr(32'h04, 32'hFFFFFFFF, 4'hF, 0, 0, 2'b00, 2'b00);
        wr(32'h04, 32'h11223344, 4'b0101, 0, 3, 2'b00, 2'b00);
        rd(32'h04, 32'hFF22FF44, 2'b00, 32'hFF22FF44, 2'b00, 2);
        wr(32'h04, 32'h0, 4'h0, 2, 0, 2'b00, 2'b00);
        rd(32'h04, 32'hFF22FF44, 2'b00, 32'hFF22FF44, 2'b00, 0);

        // Range boundary.
        wr(32'h40, 32'h1, 4'hF, 0, 0, 2'b11, 2'b11);
        rd(32'h40, 32'h0, 2'b11, 32'h0, 2'b11, 0);
        rd(32'h3C, 32'h0, 2'b00, 32'h0, 2'b00, 0);

        // B held off while a read completes.
        B_READY = 1'b0;
        fork
            wr(32'h0C, 32'hA5A5A5A5, 4'hF, 0, 0, 2'b00, 2'b00);
            begin
                repeat (2) begin @(posedge A_CLK); #1; end
                rd(32'h00, 32'h0, 2'b00, 32'h0, 2'b00, 0);
                @(negedge A_CLK);
                chk("stall_aw_ready_lit", 0, aw_rdy[0], 0);
                chk("stall_w_ready_lit", 0, w_rdy[0], 0);
                chk("stall_b_valid_lit", 0, b_vld[0], 1);
                @(posedge A_CLK); #1 B_READY = 1'b1;
            end
        join
        rd(32'h0C, 32'hA5A5A5A5, 2'b00, 32'hA5A5A5A5, 2'b00, 0);

        // Read and write of the same register on the same edge sees the old value.
        wr(32'h10, 32'h11111111, 4'hF, 0, 0, 2'b00, 2'b00);
        fork
            wr(32'h10, 32'h22222222, 4'hF, 0, 0, 2'b00, 2'b00);
            rd(32'h10, 32'h11111111, 2'b00, 32'h11111111, 2'b00, 0);
        join
        rd(32'h10, 32'h22222222, 2'b00, 32'h22222222, 2'b00, 0);

        // Reset with an address latched and data still outstanding.
        send_aw(32'h14, 0);
        A_RST = 1'b1;
        @(posedge A_CLK); #1 A_RST = 1'b0;
        @(negedge A_CLK);
        chk("mid_reset_b_valid_lit", 0, b_vld[0], 0);
        @(posedge A_CLK); #1;
        rd(32'h08, 32'h0, 2'b00, 32'h0, 2'b00, 0);
        rd(32'h10, 32'h0, 2'b00, 32'h0, 2'b00, 0);
        rd(32'h04, 32'hFFFFFFFF & 32'h0, 2'b00, 32'h0, 2'b00, 0);
        send_w(32'h99, 4'hF, 0);
        repeat (6) begin
            @(negedge A_CLK);
            chk("no_b_after_reset_lit", 0, b_vld[0], 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
